y86_execute_pipe: RTL and testbench

- Parametrised, pipelined Y86 execute stage for the PIPE processor; successor to the single-cycle SEQ execute block.
- Owns the condition-code register (ZF/SF/OF), ALU, and condition evaluation for cmov/jXX.
- Registers all results into the E→M pipeline register and supports stall/bubble control from the hazard unit.
- Also drives combinational e_valE/e_dstE for forwarding.

---
 rtl/y86_pkg.sv | 40 ++++
 rtl/y86_alu.sv | 39 +++
 rtl/y86_execute_pipe.sv | 160 ++++++++++++++++
 tb/tb_y86_execute_pipe.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 encodings: instruction codes, ALU/condition function codes,
// the "no register" ID and the condition-code record.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] I_IADDQ  = 4'hC;

  localparam logic [3:0] A_ADD = 4'h0;
  localparam logic [3:0] A_SUB = 4'h1;
  localparam logic [3:0] A_AND = 4'h2;
  localparam logic [3:0] A_XOR = 4'h3;

  localparam logic [3:0] C_ALW = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

endpackage

// File: rtl/y86_alu.sv
// Combinational Y86 ALU: add/sub/and/xor modulo 2^DATA_W with ZF/SF/OF.
module y86_alu
  import y86_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [3:0]        fun,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zf,
  output logic              sf,
  output logic              of
);

  localparam int M = DATA_W - 1;

  always_comb begin
    result = '0;
    of     = 1'b0;
    case (fun)
      A_ADD: begin
        result = b + a;
        of     = (a[M] == b[M]) && (result[M] != b[M]);
      end
      // Subtraction is b - a, so overflow keys off b's sign.
      A_SUB: begin
        result = b - a;
        of     = (a[M] != b[M]) && (result[M] != b[M]);
      end
      A_AND:   result = b & a;
      A_XOR:   result = b ^ a;
      default: result = '0;
    endcase
    zf = (result == '0);
    sf = result[M];
  end

endmodule

// File: rtl/y86_execute_pipe.sv
// Pipelined Y86 execute stage: CC register, ALU, condition evaluation, E->M register.
// Optional iaddq support is enabled by defining Y86_EXEC_IADDQ_EN.
module y86_execute_pipe
  import y86_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              E_valid,
  input  logic [3:0]        E_icode,
  input  logic [3:0]        E_ifun,
  input  logic [DATA_W-1:0] E_valA,
  input  logic [DATA_W-1:0] E_valB,
  input  logic [DATA_W-1:0] E_valC,
  input  logic [REG_W-1:0]  E_dstE,
  input  logic [REG_W-1:0]  E_dstM,
  input  logic              M_stall,
  input  logic              M_bubble,
  input  logic              cc_hold,
  output logic [DATA_W-1:0] e_valE,
  output logic [REG_W-1:0]  e_dstE,
  output logic              e_cnd,
  output logic              M_valid,
  output logic [3:0]        M_icode,
  output logic [3:0]        M_ifun,
  output logic [DATA_W-1:0] M_valE,
  output logic [DATA_W-1:0] M_valA,
  output logic [REG_W-1:0]  M_dstE,
  output logic [REG_W-1:0]  M_dstM,
  output logic              M_cnd,
  output logic              M_ins_err,
  output logic              cc_zf,
  output logic              cc_sf,
  output logic              cc_of
);

  localparam logic [REG_W-1:0]  REG_NONE  = '1;
  localparam logic [DATA_W-1:0] STACK_ADJ = DATA_W'(8);

  cc_t               cc;
  logic [3:0]        alu_fun;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_res;
  logic              alu_zf, alu_sf, alu_of;
  logic              is_iaddq, opq_ok, cc_set, ins_err, load_bubble;

  function automatic logic cond_eval(input logic [3:0] fn, input cc_t c);
    case (fn)
      C_ALW:   return 1'b1;
      C_LE:    return (c.sf ^ c.of) | c.zf;
      C_L:     return c.sf ^ c.of;
      C_E:     return c.zf;
      C_NE:    return !c.zf;
      C_GE:    return !(c.sf ^ c.of);
      C_G:     return !(c.sf ^ c.of) && !c.zf;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
`ifdef Y86_EXEC_IADDQ_EN
    is_iaddq = (E_icode == I_IADDQ);
`else
    is_iaddq = 1'b0;
`endif
    opq_ok  = (E_icode == I_OPQ) && (E_ifun <= A_XOR);
    cc_set  = E_valid && (opq_ok || is_iaddq);
    alu_fun = is_iaddq ? A_ADD : E_ifun;
    alu_a   = is_iaddq ? E_valC : E_valA;
  end

  y86_alu #(.DATA_W(DATA_W)) u_alu (
    .fun    (alu_fun),
    .a      (alu_a),
    .b      (E_valB),
    .result (alu_res),
    .zf     (alu_zf),
    .sf     (alu_sf),
    .of     (alu_of)
  );

  // Stage E: combinational results, also forwarded to decode.
  always_comb begin
    e_valE  = '0;
    e_cnd   = 1'b1;
    e_dstE  = E_valid ? E_dstE : REG_NONE;
    ins_err = 1'b0;
    if (E_valid) begin
      case (E_icode)
        I_HALT, I_NOP: ;
        I_RRMOVQ: begin
          e_cnd   = cond_eval(E_ifun, cc);
          ins_err = (E_ifun > C_G);
          e_valE  = E_valA;
          if (!e_cnd) e_dstE = REG_NONE;
        end
        I_IRMOVQ:         e_valE = E_valC;
        I_RMMOVQ, I_MRMOVQ: e_valE = E_valB + E_valC;
        I_OPQ: begin
          if (opq_ok) e_valE = alu_res;
          else        ins_err = 1'b1;
        end
        I_JXX: begin
          e_cnd   = cond_eval(E_ifun, cc);
          ins_err = (E_ifun > C_G);
          e_valE  = E_valA;
        end
        I_CALL, I_PUSHQ:  e_valE = E_valB - STACK_ADJ;
        I_RET, I_POPQ:    e_valE = E_valB + STACK_ADJ;
`ifdef Y86_EXEC_IADDQ_EN
        I_IADDQ:          e_valE = alu_res;
`endif
        default:          ins_err = 1'b1;
      endcase
    end
  end

  // CC register: a bubble into M does not block the update; stall and cc_hold do.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cc <= cc_t'(3'b100);
    end else if (cc_set && !M_stall && !cc_hold) begin
      cc <= '{zf: alu_zf, sf: alu_sf, of: alu_of};
    end
  end

  assign load_bubble = M_bubble || !E_valid;

  // Stage M: E->M pipeline register.
  always_ff @(posedge clk) begin
    if (!rst_n || (!M_stall && load_bubble)) begin
      M_valid   <= 1'b0;
      M_icode   <= I_NOP;
      M_ifun    <= 4'h0;
      M_valE    <= '0;
      M_valA    <= '0;
      M_dstE    <= REG_NONE;
      M_dstM    <= REG_NONE;
      M_cnd     <= 1'b0;
      M_ins_err <= 1'b0;
    end else if (!M_stall) begin
      M_valid   <= 1'b1;
      M_icode   <= E_icode;
      M_ifun    <= E_ifun;
      M_valE    <= e_valE;
      M_valA    <= E_valA;
      M_dstE    <= e_dstE;
      M_dstM    <= E_dstM;
      M_cnd     <= e_cnd;
      M_ins_err <= ins_err;
    end
  end

  assign cc_zf = cc.zf;
  assign cc_sf = cc.sf;
  assign cc_of = cc.of;

endmodule

// File: tb/tb_y86_execute_pipe.sv
// Directed, table-driven bench for y86_execute_pipe (DATA_W=64, REG_W=4).
module tb_y86_execute_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        E_valid;
  logic [3:0]  E_icode, E_ifun;
  logic [63:0] E_valA, E_valB, E_valC;
  logic [3:0]  E_dstE, E_dstM;
  logic        M_stall, M_bubble, cc_hold;
  logic [63:0] e_valE;
  logic [3:0]  e_dstE;
  logic        e_cnd;
  logic        M_valid;
  logic [3:0]  M_icode, M_ifun;
  logic [63:0] M_valE, M_valA;
  logic [3:0]  M_dstE, M_dstM;
  logic        M_cnd, M_ins_err;
  logic        cc_zf, cc_sf, cc_of;

  int n_cmp = 0;
  int n_err = 0;

  y86_execute_pipe #(.DATA_W(64), .REG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .E_valid(E_valid), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .M_stall(M_stall), .M_bubble(M_bubble), .cc_hold(cc_hold),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_cnd(e_cnd),
    .M_valid(M_valid), .M_icode(M_icode), .M_ifun(M_ifun), .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .M_cnd(M_cnd), .M_ins_err(M_ins_err),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
    logic [3:0]  dste;
    logic [63:0] exp_vale;
    logic        exp_cnd;
    logic [3:0]  exp_dste;
    logic        exp_err;
    logic [2:0]  exp_cc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                       input logic [3:0] dste);
    E_valid = 1'b1;
    E_icode = icode;
    E_ifun  = ifun;
    E_valA  = a;
    E_valB  = b;
    E_valC  = c;
    E_dstE  = dste;
    E_dstM  = 4'h9;
  endtask

  task automatic add_vec(input logic [3:0] icode, input logic [3:0] ifun,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                         input logic [3:0] dste, input logic [63:0] vale, input logic cnd,
                         input logic [3:0] edste, input logic err, input logic [2:0] ccv);
    vecs.push_back('{icode, ifun, a, b, c, dste, vale, cnd, edste, err, ccv});
  endtask

  function automatic logic [2:0] cc_now();
    return {cc_zf, cc_sf, cc_of};
  endfunction

  task automatic check_bubble(input string tag);
    check({tag, "_valid"}, M_valid, 1'b0);
    check({tag, "_icode"}, M_icode, 4'h1);
    check({tag, "_valE"}, M_valE, 64'h0);
    check({tag, "_dstE"}, M_dstE, 4'hF);
    check({tag, "_dstM"}, M_dstM, 4'hF);
    check({tag, "_ins_err"}, M_ins_err, 1'b0);
    check({tag, "_cc"}, cc_now(), 3'b100);
  endtask

  initial begin
    rst_n = 1'b0; M_stall = 1'b0; M_bubble = 1'b0; cc_hold = 1'b0;
    drive(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF);

    // icode ifun a b c dstE | valE cnd e_dstE err {zf,sf,of}
    add_vec(4'h6, 4'h1, 64'h1, 64'h0, 64'h0, 4'h2, 64'hFFFF_FFFF_FFFF_FFFF, 1, 4'h2, 0, 3'b010);
    add_vec(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 4'h2,
            64'hFFFF_FFFF_FFFF_FFFE, 1, 4'h2, 0, 3'b011);
    add_vec(4'h7, 4'h1, 64'h1234, 64'h0, 64'h0, 4'hF, 64'h1234, 0, 4'hF, 0, 3'b011);
    add_vec(4'h6, 4'h3, 64'h5, 64'h5, 64'h0, 4'h4, 64'h0, 1, 4'h4, 0, 3'b100);
    add_vec(4'h2, 4'h4, 64'hAA, 64'h0, 64'h0, 4'h3, 64'hAA, 0, 4'hF, 0, 3'b100);
    add_vec(4'h2, 4'h3, 64'hBB, 64'h0, 64'h0, 4'h3, 64'hBB, 1, 4'h3, 0, 3'b100);
    add_vec(4'hA, 4'h0, 64'h0, 64'h100, 64'h0, 4'h4, 64'hF8, 1, 4'h4, 0, 3'b100);
    add_vec(4'hB, 4'h0, 64'h0, 64'h100, 64'h0, 4'h4, 64'h108, 1, 4'h4, 0, 3'b100);
    add_vec(4'h3, 4'h0, 64'h0, 64'h0, 64'h55, 4'h5, 64'h55, 1, 4'h5, 0, 3'b100);
    add_vec(4'h4, 4'h0, 64'h7, 64'h10, 64'h8, 4'hF, 64'h18, 1, 4'hF, 0, 3'b100);
    add_vec(4'h6, 4'h2, 64'hF0, 64'h3C, 64'h0, 4'h6, 64'h30, 1, 4'h6, 0, 3'b000);
    add_vec(4'h6, 4'h4, 64'h1, 64'h2, 64'h0, 4'h6, 64'h0, 1, 4'h6, 1, 3'b000);
    add_vec(4'h7, 4'h7, 64'h99, 64'h0, 64'h0, 4'hF, 64'h99, 0, 4'hF, 1, 3'b000);
    add_vec(4'h6, 4'h1, 64'h5, 64'h3, 64'h0, 4'h7, 64'hFFFF_FFFF_FFFF_FFFE, 1, 4'h7, 0, 3'b010);
    add_vec(4'h7, 4'h2, 64'h40, 64'h0, 64'h0, 4'hF, 64'h40, 1, 4'hF, 0, 3'b010);
    add_vec(4'h7, 4'h6, 64'h50, 64'h0, 64'h0, 4'hF, 64'h50, 0, 4'hF, 0, 3'b010);
    add_vec(4'h0, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 64'h0, 1, 4'hF, 0, 3'b010);
    add_vec(4'h6, 4'h1, 64'h1, 64'h8000_0000_0000_0000, 64'h0, 4'h1,
            64'h7FFF_FFFF_FFFF_FFFF, 1, 4'h1, 0, 3'b001);
    add_vec(4'h7, 4'h5, 64'h60, 64'h0, 64'h0, 4'hF, 64'h60, 0, 4'hF, 0, 3'b001);
    add_vec(4'h7, 4'h1, 64'h70, 64'h0, 64'h0, 4'hF, 64'h70, 1, 4'hF, 0, 3'b001);
`ifdef Y86_EXEC_IADDQ_EN
    add_vec(4'hC, 4'h0, 64'h0, 64'd10, 64'hFFFF_FFFF_FFFF_FFF6, 4'h8, 64'h0, 1, 4'h8, 0, 3'b100);
`else
    add_vec(4'hC, 4'h0, 64'h0, 64'd10, 64'hFFFF_FFFF_FFFF_FFF6, 4'h8, 64'h0, 1, 4'h8, 1, 3'b001);
`endif

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    check_bubble("rst");
    check("rst_ifun", M_ifun, 4'h0);
    check("rst_valA", M_valA, 64'h0);
    check("rst_cnd", M_cnd, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].icode, vecs[i].ifun, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].dste);
      #1;
      check($sformatf("v%0d_e_valE", i), e_valE, vecs[i].exp_vale);
      check($sformatf("v%0d_e_cnd", i), e_cnd, vecs[i].exp_cnd);
      check($sformatf("v%0d_e_dstE", i), e_dstE, vecs[i].exp_dste);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_M_valid", i), M_valid, 1'b1);
      check($sformatf("v%0d_M_icode", i), M_icode, vecs[i].icode);
      check($sformatf("v%0d_M_valE", i), M_valE, vecs[i].exp_vale);
      check($sformatf("v%0d_M_valA", i), M_valA, vecs[i].a);
      check($sformatf("v%0d_M_dstE", i), M_dstE, vecs[i].exp_dste);
      check($sformatf("v%0d_M_dstM", i), M_dstM, 4'h9);
      check($sformatf("v%0d_M_cnd", i), M_cnd, vecs[i].exp_cnd);
      check($sformatf("v%0d_M_ins_err", i), M_ins_err, vecs[i].exp_err);
      check($sformatf("v%0d_cc", i), cc_now(), vecs[i].exp_cc);
    end

    // Reset mid-stream overrides a valid OPq
    @(negedge clk);
    drive(4'h6, 4'h0, 64'h1, 64'h1, 64'h0, 4'h2);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_bubble("midrst");

    // irmovq to seed M, then stall / cc_hold / stall+bubble / bubble
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'h3, 4'h0, 64'h0, 64'h0, 64'h77, 4'h5);
    @(posedge clk);
    #1;
    check("seed_valE", M_valE, 64'h77);

    @(negedge clk);
    drive(4'h6, 4'h0, 64'h1, 64'h1, 64'h0, 4'h2);
    M_stall = 1'b1;
    #1;
    check("stall_e_valE", e_valE, 64'h2);
    @(posedge clk);
    #1;
    check("stall_valE", M_valE, 64'h77);
    check("stall_icode", M_icode, 4'h3);
    check("stall_cc", cc_now(), 3'b100);

    @(negedge clk);
    M_stall = 1'b0;
    cc_hold = 1'b1;
    @(posedge clk);
    #1;
    check("cchold_valE", M_valE, 64'h2);
    check("cchold_icode", M_icode, 4'h6);
    check("cchold_cc", cc_now(), 3'b100);

    @(negedge clk);
    cc_hold = 1'b0;
    M_stall = 1'b1;
    M_bubble = 1'b1;
    drive(4'h6, 4'h1, 64'h3, 64'h5, 64'h0, 4'h2);
    @(posedge clk);
    #1;
    check("stbub_valE", M_valE, 64'h2);
    check("stbub_valid", M_valid, 1'b1);
    check("stbub_cc", cc_now(), 3'b100);

    @(negedge clk);
    M_stall = 1'b0;
    drive(4'h6, 4'h1, 64'h1, 64'h0, 64'h0, 4'h2);
    @(posedge clk);
    #1;
    check("bub_valid", M_valid, 1'b0);
    check("bub_icode", M_icode, 4'h1);
    check("bub_valE", M_valE, 64'h0);
    check("bub_cc", cc_now(), 3'b010);

    // Invalid E slot: NOP-like results, bubble into M, no CC write
    @(negedge clk);
    M_bubble = 1'b0;
    drive(4'h6, 4'h0, 64'h1, 64'h1, 64'h0, 4'h2);
    E_valid = 1'b0;
    #1;
    check("inv_e_valE", e_valE, 64'h0);
    check("inv_e_cnd", e_cnd, 1'b1);
    @(posedge clk);
    #1;
    check("inv_valid", M_valid, 1'b0);
    check("inv_cc", cc_now(), 3'b010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
